sum_avg_stage: RTL

SUM_AVG_STAGE -- requirements
Module: sum_avg_stage

---
 rtl/sum_avg_stage_pkg.sv | 16 +
 rtl/sum_avg_stage_max8.sv | 12 +
 rtl/sum_avg_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/sum_avg_stage_pkg.sv
// Shared definitions for the sum/average stage.
//   SUM_W  : width of the upstream sum and of the block average
//   BYTE_W : width of the upstream byte and of the block maximum
//   BLK_W  : width of the delivered-block counter
//   state_e: block FSM encoding
package sum_avg_stage_pkg;
  localparam int SUM_W  = 9;
  localparam int BYTE_W = 8;
  localparam int BLK_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/sum_avg_stage_max8.sv
// Combinational unsigned maximum of two bytes.
//   a, b : operands
//   y    : max(a, b)
module max8
  import sum_avg_stage_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] y
);
  assign y = (a >= b) ? a : b;
endmodule

// File: rtl/sum_avg_stage.sv
// Block statistics stage: collects N = 2**LOG2N samples, then presents the
// rounded mean of in_sum and the maximum in_byte until the consumer takes it.
//   clk, res            : clock, async active-low reset
//   in_valid/in_ready   : sample handshake (in_sum, in_byte)
//   out_valid/out_ready : result handshake (out_avg, out_max)
//   blk_cnt             : delivered blocks, modulo 256
module sum_avg_stage
  import sum_avg_stage_pkg::*;
#(
  parameter int LOG2N = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  input  logic [SUM_W-1:0]  in_sum,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_avg,
  output logic [BYTE_W-1:0] out_max,
  output logic [BLK_W-1:0]  blk_cnt
);
  localparam int N  = 1 << LOG2N;
  localparam int AW = SUM_W + LOG2N;  // N * 511 + N/2 still fits
  localparam int CW = LOG2N + 1;

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [BYTE_W-1:0]  mx_q, mx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SUM_W-1:0]   avg_q, avg_d;
  logic [BYTE_W-1:0]  omax_q, omax_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic [BYTE_W-1:0]  mx_new;
  logic [AW-1:0]      acc_sum;
  logic [AW-1:0]      acc_rnd;

  max8 u_max8 (.a(mx_q), .b(in_byte), .y(mx_new));

  assign accept  = in_valid & in_ready_q;
  assign acc_sum = acc_q + AW'(in_sum);
  assign acc_rnd = acc_sum + AW'(N / 2);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mx_d    = mx_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    omax_d  = omax_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d   = AW'(in_sum);
        mx_d    = in_byte;
        cnt_d   = CW'(1);
        state_d = ACC;
      end
      ACC: if (accept) begin
        acc_d = acc_sum;
        mx_d  = mx_new;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = HOLD;
          avg_d   = SUM_W'(acc_rnd >> LOG2N);
          omax_d  = mx_new;
        end
      end
      HOLD: if (out_ready) begin
        state_d = IDLE;
        blk_d   = blk_q + BLK_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered from the next state so they line up
    // with the state they describe; drain and new accept never share an edge.
    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mx_q        <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      omax_q      <= '0;
      blk_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mx_q        <= mx_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      omax_q      <= omax_d;
      blk_q       <= blk_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_avg   = avg_q;
  assign out_max   = omax_q;
  assign blk_cnt   = blk_q;
endmodule
